// File: rtl/plate_frame_rx.sv
`default_nettype none
// ============================================================================
// plate_frame_rx : UART-style frame receiver (even parity, stop check) that
//                  presents good plate codes on a held valid/ack interface.
// Revision: 1.0
// ============================================================================
module plate_frame_rx #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] plate_code,
  output logic       plate_valid,
  input  logic       plate_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic             sync1, rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             par_ok, stop_ok, done;
  logic             tick, good, deliver;

  assign tick    = (cnt == '0);
  assign busy    = (state != S_IDLE);
  assign good    = done && stop_ok && par_ok;
  assign deliver = good && (!plate_valid || plate_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      state <= S_IDLE;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rxs) state_nxt = S_START;
      S_START:     if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:      if (tick && bit_idx == 3'd7) state_nxt = S_PARITY;
      S_PARITY:    if (tick) state_nxt = S_STOP;
      S_STOP:      if (tick) state_nxt = rxs ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rxs) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Bit timing and frame capture; the stop verdict is registered in `done`
  // so the interface outputs update one edge after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      par_ok  <= 1'b0;
      stop_ok <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        cnt <= HALF_LOAD;
      end else if (tick) begin
        cnt <= FULL_LOAD;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
      if (tick) begin
        case (state)
          S_START: bit_idx <= 3'd0;
          S_DATA: begin
            shift   <= {shift[6:0], rxs};
            bit_idx <= bit_idx + 3'd1;
          end
          S_PARITY: par_ok <= ~(^{shift, rxs});
          S_STOP: begin
            stop_ok <= rxs;
            done    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plate_code  <= 8'h00;
      plate_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      frame_cnt   <= 8'h00;
    end else begin
      parity_err <= done && stop_ok && !par_ok;
      frame_err  <= done && !stop_ok;
      overrun    <= good && plate_valid && !plate_ack;
      if (deliver) begin
        plate_code  <= shift;
        plate_valid <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
      end else if (plate_ack) begin
        plate_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plate_frame_rx.sv
`default_nettype none
// ============================================================================
// tb_plate_frame_rx : directed and randomized frames against a frame-level
//                     outcome model of the receiver.
// Revision: 1.0
// ============================================================================
module tb_plate_frame_rx;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       plate_ack = 1'b0;
  logic [7:0] plate_code, frame_cnt;
  logic       plate_valid, parity_err, frame_err, overrun, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_code = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  logic       m_valid = 1'b0;

  plate_frame_rx #(.BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .plate_code(plate_code), .plate_valid(plate_valid), .plate_ack(plate_ack),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Interface state must always match the model.
  task automatic chk_iface(input string tag);
    chk({tag, "_valid"}, 32'(plate_valid), 32'(m_valid));
    chk({tag, "_code"}, 32'(plate_code), 32'(m_code));
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'(m_cnt));
  endtask

  // Sends start, data MSB first, parity, stop; the outcome lands two edges
  // after the stop bit's last cycle (sync + one-cycle verdict stage).
  task automatic frame(input logic [7:0] d, input logic par, input logic stop,
                       input logic ack_dv, input int low_hold);
    logic [10:0] bits;
    logic        exp_fe, exp_pe, exp_good, exp_dl, exp_ov;
    logic        seen;
    bits     = {1'b0, d, par, stop};
    exp_fe   = !stop;
    exp_pe   = stop && ((^d) ^ par);
    exp_good = stop && !((^d) ^ par);
    exp_ov   = exp_good && m_valid && !ack_dv;
    exp_dl   = exp_good && (!m_valid || ack_dv);
    for (int i = 0; i < 11; i++) begin
      rx_in = bits[10-i];
      step(BC);
    end
    step(1);
    chk("pre_pulses", 32'({parity_err, frame_err, overrun}), 32'(0));
    chk("pre_valid", 32'(plate_valid), 32'(m_valid));
    plate_ack = ack_dv;
    step(1);
    plate_ack = 1'b0;
    if (exp_dl) begin
      m_code  = d;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
    end else if (ack_dv) begin
      m_valid = 1'b0;
    end
    chk("parity_err", 32'(parity_err), 32'(exp_pe));
    chk("frame_err", 32'(frame_err), 32'(exp_fe));
    chk("overrun", 32'(overrun), 32'(exp_ov));
    chk_iface("deliver");
    chk("busy_after_stop", 32'(busy), 32'(exp_fe));
    step(1);
    chk("pulses_clear", 32'({parity_err, frame_err, overrun}), 32'(0));
    if (!stop) begin
      seen = 1'b1;
      for (int i = 0; i < low_hold; i++) begin
        seen = seen & busy;
        step(1);
      end
      chk("busy_held_low", 32'(seen), 32'(1));
      rx_in = 1'b1;
      step(4);
      chk("busy_released", 32'(busy), 32'(0));
    end
  endtask

  task automatic ack_pulse();
    plate_ack = 1'b1;
    step(1);
    plate_ack = 1'b0;
    m_valid   = 1'b0;
    chk("ack_clears", 32'(plate_valid), 32'(0));
  endtask

  initial begin
    logic       stable, seen;
    logic [7:0] d;
    logic       perr, serr, ackd;
    step(3);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pulses", 32'({parity_err, frame_err, overrun}), 32'(0));
    chk_iface("rst");
    rst = 1'b0;
    step(2);

    // Single good frame, then held valid
    frame(8'h49, 1'b1, 1'b1, 1'b0, 0);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      stable = stable & plate_valid & (plate_code == 8'h49);
      step(1);
    end
    chk("hold_stable", 32'(stable), 32'(1));
    ack_pulse();
    chk_iface("after_ack");

    // Parity error then good frame
    frame(8'h92, 1'b0, 1'b1, 1'b0, 0);
    frame(8'hDB, 1'b0, 1'b1, 1'b0, 0);
    ack_pulse();

    // Frame error with the line held low, then good frame
    frame(8'h24, 1'b0, 1'b0, 1'b0, 20);
    frame(8'h6D, 1'b1, 1'b1, 1'b0, 0);
    ack_pulse();

    // Overrun, then ack coinciding with delivery
    frame(8'hAE, 1'b1, 1'b1, 1'b0, 0);
    frame(8'hFF, 1'b0, 1'b1, 1'b0, 0);
    frame(8'hFF, 1'b0, 1'b1, 1'b1, 0);
    ack_pulse();

    // One-cycle glitch on the line
    rx_in = 1'b0;
    step(1);
    rx_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | parity_err | frame_err | overrun;
      step(1);
    end
    chk("glitch_pulses", 32'(seen), 32'(0));
    chk("glitch_busy", 32'(busy), 32'(0));
    chk_iface("glitch");

    // Reset during data bit 4
    frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
    rx_in = 1'b0;
    step(BC);
    for (int i = 0; i < 4; i++) begin
      rx_in = i[0];
      step(BC);
    end
    rx_in = 1'b1;
    step(2);
    #2 rst = 1'b1;
    #1;
    m_code = 8'h00; m_valid = 1'b0; m_cnt = 8'h00;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk_iface("midrst");
    step(2);
    rst = 1'b0;
    step(2);
    frame(8'h00, 1'b0, 1'b1, 1'b0, 0);

    // Randomized frames, back to back where no ack pulse intervenes
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      perr = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 5) == 0);
      ackd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) ack_pulse();
      frame(d, (^d) ^ perr, !serr, ackd, 3 + $urandom_range(0, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
